mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 0: extra memory cycles per access; legal range 0-15.
REQ-002 Parameter DATA_BURST, default 3: maximum consecutive data grants while fetch is waiting; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_f  input  1  fetch request; held high with stable addr_f until gnt_f.
REQ-006 addr_f  input  8  fetch address (read-only requester).
REQ-007 req_d  input  1  data request; held high with stable addr_d/we_d/wdata_d until gnt_d.
REQ-008 we_d  input  1  data access is a write (1) or read (0).
REQ-009 addr_d  input  8  data address.
REQ-010 wdata_d  input  8  data write value.
REQ-011 gnt_f, gnt_d  output  1 each  one-cycle grant pulse; the request has been accepted.
REQ-012 done_f, done_d  output  1 each  one-cycle completion pulse.
REQ-013 rdata  output  8  read data; valid only while done_f or done_d is high for a read.
REQ-014 mem_en  output  1  memory access enable.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  8  memory address.
REQ-017 mem_wdata  output  8  memory write data.
REQ-018 mem_rdata  input  8  memory read data; valid in the last cycle of an access.

Function
REQ-019 All outputs shall be registered.
REQ-020 FSM states shall be IDLE, ACCESS and DONE; ACCESS shall carry a 4-bit wait counter wcnt.
REQ-021 Arbitration shall occur only at clock edges where the state is IDLE or DONE and at least one request is high; requests at any other edge shall be ignored.
REQ-022 Arbitration priority:
- Data wins when both requests are high, unless starve_cnt == DATA_BURST, in which case fetch wins.
- A lone request always wins.
REQ-023 starve_cnt (4 bits) shall be handled at each arbitration:
- Incremented when data wins with req_f high.
- Cleared when fetch wins, or when data wins with req_f low.
- Shall never exceed DATA_BURST.
REQ-024 On a win, the next state shall be ACCESS, with wcnt = WAIT_STATES, the winner's address, we and wdata latched, and the owner recorded.
- gnt_x = 1 for exactly the first ACCESS cycle.
- Fetch accesses shall drive mem_we = 0 and mem_wdata = 0.
REQ-025 In ACCESS:
- mem_en = 1, with mem_we/mem_addr/mem_wdata stable for all WAIT_STATES+1 cycles.
- While wcnt != 0, wcnt shall decrement.
- At wcnt == 0, the next state shall be DONE, and rdata shall capture mem_rdata for reads.
REQ-026 In DONE:
- mem_en = 0, mem_we = 0, and done_x = 1 for the recorded owner for one cycle.
- Next state is ACCESS if a request is pending per REQ-021/022, else IDLE.
REQ-027 Writes shall also pulse done_d; rdata shall hold its previous value after a write.
REQ-028 Latency from the request-sampling edge: gnt at cycle +1, done at cycle +WAIT_STATES+2; back-to-back access period is WAIT_STATES+2 cycles.
REQ-029 gnt_f and gnt_d shall never be high together; done_f and done_d shall never be high together.
REQ-030 In IDLE, mem_en, mem_we, gnt_* and done_* shall be 0.
REQ-031 A request withdrawn before its grant shall be dropped without side effects.

Reset
REQ-032 When rst = 1 at an edge, the next state shall be:
- State IDLE, wcnt = 0 and starve_cnt = 0.
- All outputs 0, including rdata = 0x00, mem_addr = 0x00 and mem_wdata = 0x00.
REQ-033 Reset during ACCESS or DONE shall abandon the in-flight access: no done pulse is issued and no memory enable occurs in the cycle after reset.
REQ-034 rst shall take priority over all requests at the same edge.

Verification
REQ-035 WAIT_STATES=0; req_f=1, addr_f=0x10, mem_rdata=0xA5 -> gnt_f at +1, mem_en for 1 cycle at addr 0x10, done_f with rdata=0xA5 at +2.
REQ-036 WAIT_STATES=2; req_d=1, we_d=1, addr_d=0x20, wdata_d=0x5A -> mem_en=mem_we=1 for 3 cycles at addr 0x20 with data 0x5A, then done_d, rdata unchanged.
REQ-037 Simultaneous req_f and req_d held continuously, DATA_BURST=3 -> grant order d,d,d,f,d,d,d,f; each grant one cycle; no cycle with both grants.
REQ-038 WAIT_STATES=1; read accesses back-to-back -> next ACCESS begins in the cycle after DONE, giving an access period of 3 cycles with no IDLE cycle.
REQ-039 rst asserted in the second ACCESS cycle of a WAIT_STATES=3 read -> next cycle all outputs 0, no done pulse, and a fresh request is granted normally afterwards.
REQ-040 req_d pulsed high for one cycle during an ACCESS owned by fetch, then low -> no gnt_d and no data access.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter for a single-ported memory with wait states and fetch anti-starvation
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DATA_BURST  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_f,
    input  logic [7:0] addr_f,
    input  logic       req_d,
    input  logic       we_d,
    input  logic [7:0] addr_d,
    input  logic [7:0] wdata_d,
    output logic       gnt_f,
    output logic       gnt_d,
    output logic       done_f,
    output logic       done_d,
    output logic [7:0] rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t     state;
    logic [3:0] wcnt;
    logic [3:0] starve_cnt;
    logic       owner_d;
    logic       we_l;
    logic       arb;
    logic       data_win;
    // arbitration is possible outside ACCESS; data wins unless fetch has waited DATA_BURST grants
    always_comb begin
        arb      = (state != ACCESS) && (req_f || req_d);
        data_win = req_d && !(req_f && starve_cnt == 4'(DATA_BURST));
    end
    // single FSM with registered outputs: IDLE/DONE arbitrate, ACCESS counts wait states
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= 4'd0;
            starve_cnt <= 4'd0;
            owner_d    <= 1'b0;
            we_l       <= 1'b0;
            gnt_f      <= 1'b0;
            gnt_d      <= 1'b0;
            done_f     <= 1'b0;
            done_d     <= 1'b0;
            rdata      <= 8'h00;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
        end else begin
            gnt_f  <= 1'b0;
            gnt_d  <= 1'b0;
            done_f <= 1'b0;
            done_d <= 1'b0;
            case (state)
                ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        state  <= DONE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        done_f <= !owner_d;
                        done_d <= owner_d;
                        if (!we_l) rdata <= mem_rdata;
                    end
                end
                default: begin
                    if (arb) begin
                        state      <= ACCESS;
                        wcnt       <= 4'(WAIT_STATES);
                        owner_d    <= data_win;
                        we_l       <= data_win && we_d;
                        gnt_d      <= data_win;
                        gnt_f      <= !data_win;
                        mem_en     <= 1'b1;
                        mem_we     <= data_win && we_d;
                        mem_addr   <= data_win ? addr_d : addr_f;
                        mem_wdata  <= data_win ? wdata_d : 8'h00;
                        starve_cnt <= (data_win && req_f) ? starve_cnt + 4'd1 : 4'd0;
                    end else begin
                        state  <= IDLE;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
